enc_16x4_sweep: RTL and testbench
=================================

# enc_16x4_sweep

Sequential encoder/checker for the 4-to-16 decoder family. It sweeps the 4-bit select code 0..15 onto a decoder under test and re-encodes the decoder's 16 outputs back to 4 bits. Each response is checked against the ideal one-hot pattern, and faults (stuck-at, multi-hot, no-hot) are accumulated into a count, a per-code map and a first-failing code. It sits beside the faulted decoder variants as their readback and diagnosis end.

## Interface

Parameters:
- SETTLE, default 2: cycles each code is held before the sampling cycle; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  sweep request, sampled on the rising edge of clk.
- D_in  input  16  decoder-under-test outputs; bit i is the output for code i.
- X  output  1  select bit 3 (MSB) to the decoder, registered.
- Y  output  1  select bit 2, registered.
- Z  output  1  select bit 1, registered.
- W  output  1  select bit 0 (LSB), registered.
- enc_out  output  4  combinational encode of D_in: index of the highest set bit; 0 when D_in == 0.
- enc_valid  output  1  combinational; 1 iff exactly one bit of D_in is set.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- fault_cnt  output  5  number of failing codes, 0..16.
- fault_map  output  16  bit i set iff code i failed.
- first_fault  output  4  lowest failing code; 0 if none.
- any_fault  output  1  1 iff fault_cnt != 0.

## Operation

- Reset values: X=Y=Z=W=0, busy=0, done=0, fault_cnt=0, fault_map=0, first_fault=0, any_fault=0, FSM in IDLE.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1: clear fault_cnt, fault_map, first_fault and any_fault; set code=0; load the settle counter with SETTLE; go to DRIVE.
  - start=0: stay in IDLE.
- DRIVE: {X,Y,Z,W}=code; decrement the settle counter. When the counter reaches 1, go to SAMPLE.
- SAMPLE: {X,Y,Z,W}=code. A code fails iff D_in != (16'h1 << code), which is equivalent to !enc_valid or enc_out != code. On the closing edge of a failing code:
  - set fault_map[code];
  - increment fault_cnt;
  - set first_fault=code if this is the first failure of the sweep;
  - set any_fault=1.
- SAMPLE exit: if code==15, go to DONE; otherwise increment code, reload the counter and go to DRIVE.
- DONE: done=1 for exactly one cycle, {X,Y,Z,W}=0, then go to IDLE.
- busy=1 in DRIVE and SAMPLE, 0 otherwise.
- Outside DRIVE and SAMPLE, {X,Y,Z,W}=0.
- start is ignored in DRIVE, SAMPLE and DONE. It is accepted again only in IDLE.
- Results persist after DONE until the next accepted start or rst.
- rst asserted mid-sweep: all outputs take their reset values immediately, asynchronously. No partial results are retained.
- fault_cnt saturates naturally at 16 (5 bits, maximum 16 failures). It never wraps.
- enc_out and enc_valid are live at all times, independent of the FSM.

## Timing

- Start accepted at edge E0.
- Code k is driven from edge E0 + k·(SETTLE+1) for SETTLE+1 cycles.
- D_in is sampled at edge E0 + (k+1)·(SETTLE+1).
- done is high in the cycle after edge E0 + 16·(SETTLE+1). With SETTLE=2, that is 48 cycles after E0.
- Result outputs update on the sampling edge and are registered, with no combinational path from D_in.
- enc_out and enc_valid have zero latency, combinational from D_in.
- A start asserted in the DONE cycle is ignored. A start asserted in the next cycle (IDLE) is accepted.

## Test plan

- Fault-free behavioural 4x16 decoder, SETTLE=2, one start pulse. Required: done exactly 48 cycles after the accept edge, fault_cnt=0, fault_map=16'h0000, any_fault=0; X,Y,Z,W step through 0..15, each held 3 cycles.
- D_in[3] stuck-at-0. Required: fault_map=16'h0008, fault_cnt=1, first_fault=3, any_fault=1.
- D_in[0] stuck-at-1. Required: codes 1..15 are two-hot and fail, giving fault_map=16'hFFFE, fault_cnt=15, first_fault=1.
- Lower-half decoder disabled (D_in[7:0] always 0). Required: fault_map=16'h00FF, fault_cnt=8, first_fault=0. Then start again with a fault-free decoder. Required: all results cleared and ending at 0.
- rst pulsed while code=5 is driven. Required: outputs immediately at reset values. A start pulse during the following sweep is ignored; the next start after IDLE runs a full 0..15 sweep.
- Combinational encoder check:
  - D_in=16'h0120 gives enc_out=8, enc_valid=0.
  - D_in=16'h0400 gives enc_out=10, enc_valid=1.
  - D_in=0 gives enc_out=0, enc_valid=0.

Source files
------------

// File: rtl/enc_16x4_sweep.sv
// enc_16x4_sweep
//
// Readback and diagnosis end for a 4-to-16 decoder under test. After a start
// request it sweeps the select code 0..15 onto the decoder through X,Y,Z,W.
// Each code is held for SETTLE cycles plus one sampling cycle. On the closing
// edge of the sampling cycle the decoder response D_in is compared with the
// ideal one-hot pattern. Failures are accumulated into a count, a per-code map
// and the lowest failing code.
//
// Handshake: start is a level sampled on the rising clock edge. It is accepted
// only while the FSM is in IDLE and ignored everywhere else. busy is high for
// the whole sweep. done pulses for exactly one cycle when the sweep ends. The
// results then stay stable until the next accepted start or a reset.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       sweep request
//   D_in[15:0]  decoder outputs; bit i is the output for code i
//   X,Y,Z,W     registered select code to the decoder (X = MSB, W = LSB)
//   enc_out     combinational index of the highest set bit of D_in (0 if none)
//   enc_valid   combinational; 1 iff exactly one bit of D_in is set
//   busy        sweep in progress (DRIVE or SAMPLE)
//   done        one-cycle completion pulse
//   fault_cnt   number of failing codes, 0..16
//   fault_map   bit i set iff code i failed
//   first_fault lowest failing code (0 if none)
//   any_fault   1 iff at least one code failed
//   fsm_state   debug view of the FSM state (0 IDLE, 1 DRIVE, 2 SAMPLE, 3 DONE)

module enc_16x4_sweep #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] D_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        W,
    output logic [3:0]  enc_out,
    output logic        enc_valid,
    output logic        busy,
    output logic        done,
    output logic [4:0]  fault_cnt,
    output logic [15:0] fault_map,
    output logic [3:0]  first_fault,
    output logic        any_fault,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state, next_state;
    logic [3:0] code, next_code;
    logic [3:0] settle_cnt, next_cnt;
    logic [3:0] sel, next_sel;
    logic       clear_results;
    logic       code_fails;

    // ---------------------------------------------------------------
    // Live encoder, independent of the FSM
    // ---------------------------------------------------------------
    always_comb begin
        enc_out = 4'd0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < 16; i++) begin
            if (D_in[i]) enc_out = 4'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign enc_valid = (D_in != 16'd0) && ((D_in & (D_in - 16'd1)) == 16'd0);

    // ---------------------------------------------------------------
    // FSM: next state and datapath controls
    // ---------------------------------------------------------------
    assign code_fails = (D_in != (16'h0001 << code));

    always_comb begin
        next_state    = state;
        next_code     = code;
        next_cnt      = settle_cnt;
        clear_results = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clear_results = 1'b1;
                    next_code     = 4'd0;
                    next_cnt      = SETTLE_L;
                    next_state    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // The counter is loaded with SETTLE, so DRIVE lasts SETTLE cycles.
                if (settle_cnt <= 4'd1) begin
                    next_state = S_SAMPLE;
                end else begin
                    next_cnt = settle_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (code == 4'd15) begin
                    next_state = S_DONE;
                end else begin
                    next_code  = code + 4'd1;
                    next_cnt   = SETTLE_L;
                    next_state = S_DRIVE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // The select is registered from the next-state values so that X..W change
    // on the same edge as the FSM and never glitch.
    always_comb begin
        next_sel = 4'd0;
        if (next_state == S_DRIVE || next_state == S_SAMPLE) begin
            next_sel = next_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            code       <= 4'd0;
            settle_cnt <= 4'd0;
            sel        <= 4'd0;
        end else begin
            state      <= next_state;
            code       <= next_code;
            settle_cnt <= next_cnt;
            sel        <= next_sel;
        end
    end

    // ---------------------------------------------------------------
    // Result accumulation on the closing edge of each SAMPLE cycle
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt   <= 5'd0;
            fault_map   <= 16'd0;
            first_fault <= 4'd0;
            any_fault   <= 1'b0;
        end else if (clear_results) begin
            fault_cnt   <= 5'd0;
            fault_map   <= 16'd0;
            first_fault <= 4'd0;
            any_fault   <= 1'b0;
        end else if (state == S_SAMPLE && code_fails) begin
            fault_map[code] <= 1'b1;
            // Each code is sampled once per sweep, so at most 16 increments
            // and the 5-bit count cannot wrap.
            fault_cnt       <= fault_cnt + 5'd1;
            if (fault_cnt == 5'd0) first_fault <= code;
            any_fault       <= 1'b1;
        end
    end

    assign {X, Y, Z, W} = sel;
    assign busy         = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done         = (state == S_DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_enc_16x4_sweep.sv
module tb_enc_16x4_sweep;

    localparam int SETTLE = 2;
    localparam int HOLD   = SETTLE + 1;
    localparam int SWEEP  = 16 * HOLD;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] D_in;
    logic        X, Y, Z, W;
    logic [3:0]  enc_out;
    logic        enc_valid;
    logic        busy;
    logic        done;
    logic [4:0]  fault_cnt;
    logic [15:0] fault_map;
    logic [3:0]  first_fault;
    logic        any_fault;
    logic [1:0]  fsm_state;

    // Decoder-under-test model: ideal one-hot with stuck-at-0/1 masks,
    // or a forced raw value for the encoder checks.
    logic [15:0] stuck0;
    logic [15:0] stuck1;
    logic        force_en;
    logic [15:0] force_val;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    enc_16x4_sweep #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .D_in(D_in),
        .X(X), .Y(Y), .Z(Z), .W(W),
        .enc_out(enc_out), .enc_valid(enc_valid),
        .busy(busy), .done(done),
        .fault_cnt(fault_cnt), .fault_map(fault_map),
        .first_fault(first_fault), .any_fault(any_fault),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (force_en) D_in = force_val;
        else          D_in = ((16'h0001 << {X, Y, Z, W}) & ~stuck0) | stuck1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: which codes fail for a given stuck-at pattern.
    function automatic logic [15:0] ref_map(input logic [15:0] s0, input logic [15:0] s1);
        logic [15:0] m;
        logic [15:0] ideal;
        m = 16'd0;
        for (int k = 0; k < 16; k++) begin
            ideal = 16'd1 << k;
            if ((((ideal & ~s0) | s1)) != ideal) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic check_results(input string tag, input logic [15:0] exp_map);
        int n;
        int first;
        n = 0;
        first = -1;
        for (int k = 0; k < 16; k++) begin
            if (exp_map[k]) begin
                n++;
                if (first < 0) first = k;
            end
        end
        if (first < 0) first = 0;
        check({tag, "_map"},   fault_map,   exp_map);
        check({tag, "_cnt"},   fault_cnt,   n);
        check({tag, "_first"}, first_fault, first);
        check({tag, "_any"},   any_fault,   (n != 0));
    endtask

    // Start a sweep and follow it to done. Optionally checks the select
    // staircase, pulses start at cycle ignore_at (must be ignored), and
    // holds start high during the done cycle (must also be ignored).
    task automatic run_sweep(input string tag, input bit chk_sel,
                             input int ignore_at, input bit poke_done);
        int j;
        bit seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        j = 0;
        seen = 1'b0;
        while (j < 400 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (j == ignore_at);
                if (chk_sel && j < SWEEP) begin
                    check({tag, "_sel"},  {X, Y, Z, W}, j / HOLD);
                    check({tag, "_busy"}, busy, 1'b1);
                end
                @(negedge clk);
                j++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_latency"},   j, SWEEP);
        check({tag, "_sel_done"},  {X, Y, Z, W}, 4'd0);
        if (poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"},       busy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},   {X, Y, Z, W}, 4'd0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check_results(tag, 16'h0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rm;
        logic [15:0] v;
        int exp_idx;
        int ones;

        rst       = 1'b1;
        start     = 1'b0;
        stuck0    = 16'h0000;
        stuck1    = 16'h0000;
        force_en  = 1'b0;
        force_val = 16'h0000;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fault-free sweep with staircase check and start poked in DONE.
        run_sweep("clean", 1'b1, -1, 1'b1);
        check_results("clean", 16'h0000);

        // D_in[3] stuck-at-0.
        stuck0 = 16'h0008;
        run_sweep("s0_b3", 1'b0, -1, 1'b0);
        check_results("s0_b3", 16'h0008);
        check("s0_b3_spec_map", fault_map, ref_map(16'h0008, 16'h0000));
        stuck0 = 16'h0000;

        // D_in[0] stuck-at-1: codes 1..15 are two-hot.
        stuck1 = 16'h0001;
        run_sweep("s1_b0", 1'b0, -1, 1'b0);
        check_results("s1_b0", 16'hFFFE);
        stuck1 = 16'h0000;

        // Lower half disabled, then a clean rerun clears everything.
        stuck0 = 16'h00FF;
        run_sweep("lower", 1'b0, -1, 1'b0);
        check_results("lower", 16'h00FF);
        stuck0 = 16'h0000;
        run_sweep("rerun", 1'b1, -1, 1'b0);
        check_results("rerun", 16'h0000);

        // Reset while code 5 is driven, with partial faults already counted.
        stuck0 = 16'h00FF;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5 * HOLD) @(negedge clk);
        check("mid_sel", {X, Y, Z, W}, 4'd5);
        check("mid_cnt", fault_cnt, 5'd5);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk); rst = 1'b0;
        stuck0 = 16'h0000;
        // A start pulse mid-sweep must not restart it.
        run_sweep("ignore", 1'b1, 20, 1'b0);
        check_results("ignore", 16'h0000);
        run_sweep("after", 1'b1, -1, 1'b0);
        check_results("after", 16'h0000);

        // Random stuck-at patterns against the reference model.
        for (int r = 0; r < 4; r++) begin
            stuck0 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            stuck1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            rm = ref_map(stuck0, stuck1);
            run_sweep("rand", 1'b0, -1, 1'b0);
            check_results("rand", rm);
        end
        stuck0 = 16'h0000;
        stuck1 = 16'h0000;

        // Combinational encoder: directed values.
        force_en = 1'b1;
        force_val = 16'h0120; #1;
        check("enc_0120_out", enc_out, 4'd8);
        check("enc_0120_val", enc_valid, 1'b0);
        force_val = 16'h0400; #1;
        check("enc_0400_out", enc_out, 4'd10);
        check("enc_0400_val", enc_valid, 1'b1);
        force_val = 16'h0000; #1;
        check("enc_0000_out", enc_out, 4'd0);
        check("enc_0000_val", enc_valid, 1'b0);

        // Combinational encoder: random values, half of them one-hot.
        for (int r = 0; r < 24; r++) begin
            if (r % 2 == 0) v = 16'd1 << $urandom_range(15, 0);
            else            v = 16'($urandom);
            force_val = v;
            #1;
            exp_idx = 0;
            ones = 0;
            for (int k = 15; k >= 0; k--) begin
                if (v[k]) begin
                    ones++;
                    if (ones == 1) exp_idx = k;
                end
            end
            check("enc_rand_out", enc_out, exp_idx);
            check("enc_rand_val", enc_valid, (ones == 1));
        end
        force_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
